// File: rtl/display_scan.sv
// Scans a DATA_W word out as S = DATA_W/OUT_W slices, MS slice first, each held DWELL clocks.
// Outputs are registered, 1 clk after a capture edge; freeze stalls everything. Optional blank slot: DISPLAY_SCAN_BLANK_EN.
module display_scan #(
  parameter int DATA_W = 32,
  parameter int OUT_W  = 16,
  parameter int DWELL  = 1,
  localparam int S     = DATA_W / OUT_W,
  localparam int IDX_W = ($clog2(S) > 1) ? $clog2(S) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              freeze,
  output logic [OUT_W-1:0]  reg_data_output,
  output logic [IDX_W-1:0]  slice_idx,
  output logic              frame_start
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(S - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHOW  = 2'd1;
  localparam logic [1:0] ST_BLANK = 2'd2;

  logic [1:0]        state, state_n;
  logic [DATA_W-1:0] snapshot, snap_n;
  logic [CNT_W-1:0]  dwell_cnt, cnt_n;
  logic [IDX_W-1:0]  idx_n;
  logic [OUT_W-1:0]  out_n;
  logic              fs_n;
  logic              capture;

  function automatic logic [OUT_W-1:0] slice_of(input logic [DATA_W-1:0] w,
                                                input int unsigned k);
    return w[DATA_W-1-k*OUT_W -: OUT_W];
  endfunction

  always_comb begin
    state_n = state;
    snap_n  = snapshot;
    cnt_n   = dwell_cnt;
    idx_n   = slice_idx;
    out_n   = reg_data_output;
    fs_n    = 1'b0;
    capture = 1'b0;
    case (state)
      ST_SHOW: begin
        if (dwell_cnt != LAST_CNT) begin
          cnt_n = dwell_cnt + CNT_W'(1);
        end else begin
`ifdef DISPLAY_SCAN_BLANK_EN
          state_n = ST_BLANK;
          cnt_n   = '0;
          out_n   = '0;
          idx_n   = (slice_idx == LAST_IDX) ? '0 : slice_idx + IDX_W'(1);
`else
          if (slice_idx == LAST_IDX) begin
            capture = 1'b1;
          end else begin
            cnt_n = '0;
            idx_n = slice_idx + IDX_W'(1);
            out_n = slice_of(snapshot, int'(slice_idx) + 1);
          end
`endif
        end
      end
      ST_BLANK: begin
        // Index 0 is only reached in blank at a wrap, so it doubles as the wrap flag.
        if (slice_idx == '0) begin
          capture = 1'b1;
        end else begin
          state_n = ST_SHOW;
          out_n   = slice_of(snapshot, int'(slice_idx));
        end
      end
      default: capture = 1'b1;
    endcase
    if (capture) begin
      state_n = ST_SHOW;
      snap_n  = reg_data;
      out_n   = slice_of(reg_data, 0);
      idx_n   = '0;
      cnt_n   = '0;
      fs_n    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      snapshot        <= '0;
      dwell_cnt       <= '0;
      slice_idx       <= '0;
      reg_data_output <= '0;
      frame_start     <= 1'b0;
    end else if (freeze) begin
      frame_start <= 1'b0;
    end else begin
      state           <= state_n;
      snapshot        <= snap_n;
      dwell_cnt       <= cnt_n;
      slice_idx       <= idx_n;
      reg_data_output <= out_n;
      frame_start     <= fs_n;
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan: default, DWELL=3 and 64-bit instances on one clock.
module tb_display_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // default instance
  logic        rst_a = 1'b0, frz_a = 1'b0;
  logic [31:0] dat_a = '0;
  logic [15:0] out_a;
  logic        idx_a, fs_a;
  // DWELL = 3
  logic        rst_b = 1'b0, frz_b = 1'b0;
  logic [31:0] dat_b = '0;
  logic [15:0] out_b;
  logic        idx_b, fs_b;
  // 64-bit word, four slices
  logic        rst_c = 1'b0, frz_c = 1'b0;
  logic [63:0] dat_c = '0;
  logic [15:0] out_c;
  logic [1:0]  idx_c;
  logic        fs_c;

  display_scan u_dut_a (.clk(clk), .rst_n(rst_a), .reg_data(dat_a), .freeze(frz_a),
                        .reg_data_output(out_a), .slice_idx(idx_a), .frame_start(fs_a));
  display_scan #(.DWELL(3)) u_dut_b (.clk(clk), .rst_n(rst_b), .reg_data(dat_b), .freeze(frz_b),
                        .reg_data_output(out_b), .slice_idx(idx_b), .frame_start(fs_b));
  display_scan #(.DATA_W(64)) u_dut_c (.clk(clk), .rst_n(rst_c), .reg_data(dat_c), .freeze(frz_c),
                        .reg_data_output(out_c), .slice_idx(idx_c), .frame_start(fs_c));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [15:0] o, input logic i, input logic f);
    chk({tag, ".out"}, 64'(out_a), 64'(o));
    chk({tag, ".idx"}, 64'(idx_a), 64'(i));
    chk({tag, ".fs"},  64'(fs_a),  64'(f));
  endtask

  task automatic chk_b(input string tag, input logic [15:0] o, input logic f);
    chk({tag, ".out"}, 64'(out_b), 64'(o));
    chk({tag, ".fs"},  64'(fs_b),  64'(f));
  endtask

  task automatic chk_c(input string tag, input logic [15:0] o, input logic [1:0] i, input logic f);
    chk({tag, ".out"}, 64'(out_c), 64'(o));
    chk({tag, ".idx"}, 64'(idx_c), 64'(i));
    chk({tag, ".fs"},  64'(fs_c),  64'(f));
  endtask

  initial begin
    logic [15:0] exp_b [6];
    logic        fs_exp_b [6];
    int          fs_cnt;

    dat_a = 32'hDEADBEEF;
    frz_a = 1'b1;            // reset must win over freeze
    tick();
    tick();
    chk_a("reset_a", 16'h0000, 1'b0, 1'b0);
    frz_a = 1'b0;
    rst_a = 1'b1;

`ifdef DISPLAY_SCAN_BLANK_EN
    tick(); chk_a("blank_e1", 16'hDEAD, 1'b0, 1'b1);
    tick(); chk_a("blank_e2", 16'h0000, 1'b1, 1'b0);
    tick(); chk_a("blank_e3", 16'hBEEF, 1'b1, 1'b0);
    tick(); chk_a("blank_e4", 16'h0000, 1'b0, 1'b0);
    tick(); chk_a("blank_e5", 16'hDEAD, 1'b0, 1'b1);
    frz_a = 1'b1;
    tick(); tick(); chk_a("blank_frz", 16'hDEAD, 1'b0, 1'b0);
    frz_a = 1'b0;
    tick(); chk_a("blank_e6", 16'h0000, 1'b1, 1'b0);
    tick(); chk_a("blank_e7", 16'hBEEF, 1'b1, 1'b0);
`else
    // one slice per clock, frame_start on every DEAD
    tick(); chk_a("a_e1", 16'hDEAD, 1'b0, 1'b1);
    tick(); chk_a("a_e2", 16'hBEEF, 1'b1, 1'b0);
    tick(); chk_a("a_e3", 16'hDEAD, 1'b0, 1'b1);
    dat_a = 32'h12345678;    // mid-frame change must not touch slice 1
    tick(); chk_a("a_coh", 16'hBEEF, 1'b1, 1'b0);
    tick(); chk_a("a_new0", 16'h1234, 1'b0, 1'b1);
    tick(); chk_a("a_new1", 16'h5678, 1'b1, 1'b0);
    // freeze on a wrap edge defers the recapture
    frz_a = 1'b1;
    dat_a = 32'hCAFEF00D;
    tick(); chk_a("a_frz_wrap", 16'h5678, 1'b1, 1'b0);
    frz_a = 1'b0;
    tick(); chk_a("a_after_frz", 16'hCAFE, 1'b0, 1'b1);
    tick(); chk_a("a_after_frz1", 16'hF00D, 1'b1, 1'b0);

    // DWELL = 3: each slice held 3 clocks, one frame_start in 6
    dat_b = 32'hDEADBEEF;
    tick();
    chk_b("reset_b", 16'h0000, 1'b0);
    rst_b = 1'b1;
    exp_b    = '{16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hBEEF, 16'hBEEF, 16'hBEEF};
    fs_exp_b = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    fs_cnt = 0;
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 6; k++) begin
        tick();
        chk_b($sformatf("b_f%0d_c%0d", f, k), exp_b[k], fs_exp_b[k]);
        if (fs_b) fs_cnt++;
      end
    end
    chk("b_fs_count", 64'(fs_cnt), 64'd2);
    // edges 13..14: DEAD (cnt0,1) ... reach BEEF second dwell cycle
    tick(); chk_b("b_e13", 16'hDEAD, 1'b1);
    tick(); tick();
    tick(); chk_b("b_e16", 16'hBEEF, 1'b0);
    tick(); chk_b("b_e17", 16'hBEEF, 1'b0);
    frz_b = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_b($sformatf("b_frz%0d", k), 16'hBEEF, 1'b0);
    end
    frz_b = 1'b0;
    tick(); chk_b("b_resume", 16'hBEEF, 1'b0);
    tick(); chk_b("b_wrap", 16'hDEAD, 1'b1);

    // 64-bit: four slices, reset mid-frame restarts at slice 0
    dat_c = 64'h0123456789ABCDEF;
    tick();
    chk_c("reset_c", 16'h0000, 2'd0, 1'b0);
    rst_c = 1'b1;
    tick(); chk_c("c_s0", 16'h0123, 2'd0, 1'b1);
    tick(); chk_c("c_s1", 16'h4567, 2'd1, 1'b0);
    tick(); chk_c("c_s2", 16'h89AB, 2'd2, 1'b0);
    rst_c = 1'b0;
    tick(); chk_c("c_rst", 16'h0000, 2'd0, 1'b0);
    rst_c = 1'b1;
    tick(); chk_c("c_re0", 16'h0123, 2'd0, 1'b1);
    tick(); chk_c("c_re1", 16'h4567, 2'd1, 1'b0);
    tick(); chk_c("c_re2", 16'h89AB, 2'd2, 1'b0);
    tick(); chk_c("c_re3", 16'hCDEF, 2'd3, 1'b0);
    tick(); chk_c("c_wrap", 16'h0123, 2'd0, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_scan.md
DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 Parameter DATA_W, default 32, width of the word being displayed.
REQ-002 Parameter OUT_W, default 16, width of one displayed slice; DATA_W SHALL be an integer multiple of OUT_W, with S = DATA_W/OUT_W >= 2.
REQ-003 Parameter DWELL, default 1, number of clocks each slice is shown; DWELL >= 1.
REQ-004 Derived IDX_W = max(1, clog2(S)).
REQ-005 clk  input  1  single clock; all state updates on posedge clk.
REQ-006 rst_n  input  1  synchronous, active-low reset.
REQ-007 reg_data  input  DATA_W  live word to display.
REQ-008 freeze  input  1  when high, all internal state and outputs hold.
REQ-009 reg_data_output  output  OUT_W  currently displayed slice, registered.
REQ-010 slice_idx  output  IDX_W  index of displayed slice, 0 = most significant, registered.
REQ-011 frame_start  output  1  one-cycle pulse, high while slice 0 of a new frame is first shown.

Function
REQ-012 Slice k SHALL be reg_data bits [DATA_W-1-k*OUT_W -: OUT_W], shown in order k = 0..S-1, then wrapping to 0.
REQ-013 Internal registers: snapshot (DATA_W), dwell counter, slice_idx, primed flag.
REQ-014 The first unfrozen edge after reset release SHALL load snapshot <= reg_data, reg_data_output <= slice 0 of live reg_data, slice_idx <= 0, dwell counter <= 0, frame_start <= 1, and primed <= 1.
REQ-015 On each unfrozen edge with primed set, if dwell counter < DWELL-1, the counter SHALL increment and the outputs SHALL hold.
REQ-016 When dwell counter == DWELL-1 and slice_idx < S-1, the counter SHALL clear, slice_idx SHALL increment, and reg_data_output SHALL take the next slice of the snapshot.
REQ-017 When dwell counter == DWELL-1 and slice_idx == S-1 (wrap), the block SHALL recapture snapshot <= reg_data, output slice 0 of live reg_data, set slice_idx <= 0, and pulse frame_start.
REQ-018 Frame coherency: changes on reg_data mid-frame SHALL NOT affect slices 1..S-1 of the current frame.
REQ-019 frame_start SHALL be 0 on every edge other than those in REQ-014 and REQ-017.
REQ-020 freeze high SHALL hold snapshot, counter, slice_idx and reg_data_output, and SHALL force frame_start to 0; the remaining dwell resumes unchanged after release.
REQ-021 When freeze is asserted on a wrap edge, the recapture SHALL be deferred until the first unfrozen wrap edge.
REQ-022 Output latency: reg_data_output reflects live reg_data one clock after a capture edge; there are no combinational paths from inputs to outputs.

Reset
REQ-023 rst_n low at a posedge SHALL clear reg_data_output, slice_idx, frame_start, snapshot, dwell counter and primed to 0, overriding freeze.
REQ-024 A reset asserted mid-frame SHALL abandon the frame; after release, operation restarts per REQ-014.

Configuration
REQ-025 Macro DISPLAY_SCAN_BLANK_EN: when defined, a BLANK state of exactly one clock SHALL follow the last dwell cycle of every slice, including the last slice before a wrap.
REQ-026 In BLANK, reg_data_output SHALL be 0 and slice_idx SHALL already show the next index; the following edge shows that slice, or performs the capture at a wrap, which pulses frame_start.
REQ-027 freeze SHALL hold BLANK the same way it holds any other state.
REQ-028 When DISPLAY_SCAN_BLANK_EN is undefined, no BLANK state exists and the timing of REQ-015 to REQ-017 applies exactly.

Verification
REQ-029 Defaults, reg_data=0xDEADBEEF, release reset -> output 0xDEAD,0xBEEF,0xDEAD,... one per clock; frame_start high on each 0xDEAD cycle.
REQ-030 Change reg_data to 0x12345678 while 0xDEAD is shown -> next cycle output is 0xBEEF, then 0x1234, then 0x5678.
REQ-031 DWELL=3 -> each slice held 3 clocks, frame period 6, frame_start high for 1 of 6 cycles.
REQ-032 freeze high for 5 clocks during the 2nd dwell cycle of 0xBEEF (DWELL=3) -> 0xBEEF held 5 extra clocks, then 1 more, then 0xDEAD.
REQ-033 DATA_W=64, OUT_W=16, reg_data=0x0123456789ABCDEF -> 0x0123,0x4567,0x89AB,0xCDEF, slice_idx 0..3; rst_n low during slice 2 -> output 0 and slice_idx 0, then restart at 0x0123.
REQ-034 With DISPLAY_SCAN_BLANK_EN, defaults, reg_data=0xDEADBEEF -> output 0xDEAD,0x0000,0xBEEF,0x0000,0xDEAD,...
